branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/branch_predictor.sv | 123 ++++++++++++
 tb/tb_branch_predictor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg
//   Shared constants and helpers for the branch predictor slice.
//   - PC_INC          : sequential fetch increment (fall-through PC = pc + PC_INC)
//   - weak_taken()    : counter value with MSB set, all lower bits clear
//   - weak_not_taken(): counter value with MSB clear, all lower bits set
// The helpers return 32-bit values; callers cast to their counter width.
package bp_pkg;

    localparam int unsigned PC_INC = 4;

    function automatic logic [31:0] weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] weak_not_taken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Next-state logic for a CTR_W-bit saturating up/down counter.
//   Ports:
//     value      : current counter value
//     up         : 1 = count up, 0 = count down
//     next_value : updated value, clamped at all-ones and zero
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] value,
    input  logic             up,
    output logic [CTR_W-1:0] next_value
);

    always_comb begin
        next_value = value;
        if (up) begin
            if (value != '1) next_value = value + CTR_W'(1);
        end else begin
            if (value != '0) next_value = value - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor
//   Direct-mapped BTB with a per-entry saturating direction counter.
//   Ports:
//     clk_i, rst_i        : clock, asynchronous active-low reset
//     lookup_valid_i/pc_i : fetch-stage lookup request
//     pred_valid_o        : registered prediction valid (1 cycle after lookup)
//     pred_hit_o          : lookup matched a valid entry
//     pred_taken_o        : predicted direction
//     pred_target_o       : predicted next PC
//     update_*_i          : resolved branch from ID (pc, direction, target, flush)
//     mispred_cnt_o       : saturating count of flushed branches
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_valid_o,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic              update_taken_i,
    input  logic [ADDR_W-1:0] update_target_i,
    input  logic              update_mispred_i,
    output logic [CNT_W-1:0]  mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem    [ENTRIES];
    logic [ADDR_W-1:0]  target_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem    [ENTRIES];

    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [TAG_W-1:0] lkp_tag, upd_tag;
    logic             lkp_hit, lkp_taken, upd_hit;
    logic [CTR_W-1:0] ctr_next;

    // Byte offset bits of the update PC never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^update_pc_i[1:0];

    assign lkp_idx = lookup_pc_i[IDX_W+1:2];
    assign lkp_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign upd_idx = update_pc_i[IDX_W+1:2];
    assign upd_tag = update_pc_i[ADDR_W-1:IDX_W+2];

    assign lkp_hit   = valid_q[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
    assign lkp_taken = lkp_hit && ctr_mem[lkp_idx][CTR_W-1];
    assign upd_hit   = valid_q[upd_idx] && (tag_mem[upd_idx] == upd_tag);

    sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .value      (ctr_mem[upd_idx]),
        .up         (update_taken_i),
        .next_value (ctr_next)
    );

    // The prediction is resolved from the table contents sampled at the lookup
    // edge, so a same-cycle update only becomes visible to later lookups.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pred_valid_o  <= 1'b0;
            pred_hit_o    <= 1'b0;
            pred_taken_o  <= 1'b0;
            pred_target_o <= '0;
        end else begin
            pred_valid_o <= lookup_valid_i;
            pred_hit_o   <= lookup_valid_i && lkp_hit;
            pred_taken_o <= lookup_valid_i && lkp_taken;
            if (!lookup_valid_i)
                pred_target_o <= '0;
            else if (lkp_taken)
                pred_target_o <= target_mem[lkp_idx];
            else
                pred_target_o <= lookup_pc_i + ADDR_W'(PC_INC);
        end
    end

    // Valid bits and counters: hits train the counter, taken misses allocate
    // with a weakly-taken counter, not-taken misses leave the table alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctr_mem[i] <= CTR_W'(weak_not_taken(CTR_W));
        end else if (update_valid_i) begin
            if (upd_hit) begin
                ctr_mem[upd_idx] <= ctr_next;
            end else if (update_taken_i) begin
                valid_q[upd_idx] <= 1'b1;
                ctr_mem[upd_idx] <= CTR_W'(weak_taken(CTR_W));
            end
        end
    end

    // Tag and target need no reset because valid gates their use. Any taken
    // update either hits (same tag, new target) or allocates (new tag and
    // target), so both cases reduce to a plain write.
    always_ff @(posedge clk_i) begin
        if (update_valid_i && update_taken_i) begin
            tag_mem[upd_idx]    <= upd_tag;
            target_mem[upd_idx] <= update_target_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            mispred_cnt_o <= '0;
        else if (update_valid_i && update_mispred_i && (mispred_cnt_o != '1))
            mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Randomized and directed stimulus for branch_predictor (ENTRIES=16, CTR_W=2,
//   ADDR_W=32, CNT_W=4) checked against a table model kept in the bench.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_valid, pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispred;
    logic [3:0]  mispred_cnt;

    int total = 0;
    int bad   = 0;

    // reference model: one slot per index, counter kept as a plain integer 0..3
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_cnt;

    always #5 clk = ~clk;

    branch_predictor #(
        .ENTRIES (16),
        .CTR_W   (2),
        .ADDR_W  (32),
        .CNT_W   (4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .lookup_valid_i   (lookup_valid),
        .lookup_pc_i      (lookup_pc),
        .pred_valid_o     (pred_valid),
        .pred_hit_o       (pred_hit),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .update_valid_i   (update_valid),
        .update_pc_i      (update_pc),
        .update_taken_i   (update_taken),
        .update_target_i  (update_target),
        .update_mispred_i (update_mispred),
        .mispred_cnt_o    (mispred_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_update(input bit uv, input logic [31:0] pc, input bit taken,
                                         input logic [31:0] tgt, input bit mis);
        int idx;
        if (!uv) return;
        idx = int'((pc >> 2) % 16);
        if (m_valid[idx] && m_tag[idx] == (pc >> 6)) begin
            m_ctr[idx] = taken ? ((m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1)
                               : ((m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1);
            if (taken) m_tgt[idx] = tgt;
        end else if (taken) begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = pc >> 6;
            m_tgt[idx]   = tgt;
            m_ctr[idx]   = 2;
        end
        if (mis && m_cnt < 15) m_cnt++;
    endfunction

    // Called at a falling edge: drives one cycle of inputs, lets the edge pass,
    // then checks the prediction and counter at the next falling edge.
    task automatic applyStimulus(input bit lv, input logic [31:0] lpc, input bit uv,
                                 input logic [31:0] upc, input bit ut,
                                 input logic [31:0] utgt, input bit um);
        int          idx;
        bit          e_hit, e_taken;
        logic [31:0] e_tgt;
        lookup_valid   = lv;
        lookup_pc      = lpc;
        update_valid   = uv;
        update_pc      = upc;
        update_taken   = ut;
        update_target  = utgt;
        update_mispred = um;
        idx     = int'((lpc >> 2) % 16);
        e_hit   = m_valid[idx] && (m_tag[idx] == (lpc >> 6));
        e_taken = e_hit && (m_ctr[idx] >= 2);
        e_tgt   = e_taken ? m_tgt[idx] : lpc + 32'd4;
        @(posedge clk);
        model_update(uv, upc, ut, utgt, um);
        @(negedge clk);
        checkOutput("pred_valid", pred_valid, lv);
        if (lv) begin
            checkOutput("pred_hit", pred_hit, e_hit);
            checkOutput("pred_taken", pred_taken, e_taken);
            checkOutput("pred_target", pred_target, e_tgt);
        end
        checkOutput("mispred_cnt", mispred_cnt, m_cnt);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, pred_valid, 0);
        checkOutput({tag, "_hit"}, pred_hit, 0);
        checkOutput({tag, "_taken"}, pred_taken, 0);
        checkOutput({tag, "_target"}, pred_target, 0);
        checkOutput({tag, "_cnt"}, mispred_cnt, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] pc;
        pc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FC00;
        return pc;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        lookup_valid   = 1'b0;
        lookup_pc      = '0;
        update_valid   = 1'b0;
        update_pc      = '0;
        update_taken   = 1'b0;
        update_target  = '0;
        update_mispred = 1'b0;
        model_reset();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // cold lookup misses and falls through
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("cold_hit", pred_hit, 0);
        checkOutput("cold_target", pred_target, 32'h44);

        // allocation then hit
        applyStimulus(0, 0, 1, 32'h40, 1, 32'h100, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("alloc_hit", pred_hit, 1);
        checkOutput("alloc_taken", pred_taken, 1);
        checkOutput("alloc_target", pred_target, 32'h100);

        // counter saturates at zero, then retrains
        repeat (3) applyStimulus(0, 0, 1, 32'h40, 0, 0, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("nt_hit", pred_hit, 1);
        checkOutput("nt_taken", pred_taken, 0);
        checkOutput("nt_target", pred_target, 32'h44);
        applyStimulus(1, 32'h40, 1, 32'h40, 1, 32'h200, 0);
        checkOutput("one_up_taken", pred_taken, 0);
        applyStimulus(1, 32'h40, 1, 32'h40, 1, 32'h200, 0);
        checkOutput("two_up_taken", pred_taken, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("retrain_taken", pred_taken, 1);
        checkOutput("retrain_target", pred_target, 32'h200);

        // aliasing: 0x80 evicts 0x40 at index 0
        applyStimulus(0, 0, 1, 32'h80, 1, 32'h300, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("alias_old_hit", pred_hit, 0);
        applyStimulus(1, 32'h80, 0, 0, 0, 0, 0);
        checkOutput("alias_new_hit", pred_hit, 1);
        checkOutput("alias_new_target", pred_target, 32'h300);

        // same-cycle lookup and allocation returns the old entry
        applyStimulus(1, 32'h40, 1, 32'h40, 1, 32'h140, 0);
        checkOutput("rbw_hit", pred_hit, 0);
        checkOutput("rbw_target", pred_target, 32'h44);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("rbw_next_hit", pred_hit, 1);
        checkOutput("rbw_next_target", pred_target, 32'h140);

        // low PC bits are ignored; fall-through wraps at the top of memory
        applyStimulus(0, 0, 1, 32'h43, 1, 32'h500, 0);
        applyStimulus(1, 32'h41, 0, 0, 0, 0, 0);
        checkOutput("lowbits_target", pred_target, 32'h500);
        applyStimulus(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        checkOutput("wrap_target", pred_target, 32'h0);

        // random traffic over a small PC pool so indices collide often
        for (int i = 0; i < 400; i++) begin
            logic [31:0] lpc, upc;
            lpc = ($urandom_range(0, 2) == 0) ? rand_pc() : upc_prev_or_rand();
            upc = rand_pc();
            if ($urandom_range(0, 3) == 0) upc = lpc;
            applyStimulus(1'($urandom_range(0, 1)), lpc, 1'($urandom_range(0, 3) != 0), upc,
                          1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        end

        // reset while a lookup is in flight
        lookup_valid   = 1'b1;
        lookup_pc      = 32'h40;
        update_valid   = 1'b1;
        update_mispred = 1'b1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        model_reset();
        @(negedge clk);
        lookup_valid   = 1'b0;
        update_valid   = 1'b0;
        update_mispred = 1'b0;
        rst_n          = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_valid", pred_valid, 0);
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 0);
        checkOutput("post_rst_hit", pred_hit, 0);

        // mispredict counter saturates at 15
        repeat (20) applyStimulus(0, 0, 1, rand_pc(), 1'($urandom_range(0, 1)), $urandom, 1);
        checkOutput("cnt_sat", mispred_cnt, 15);

        // reset during activity clears every output immediately
        applyStimulus(0, 0, 1, 32'h40, 1, 32'h700, 0);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        update_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_rst_hit", pred_hit, 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("final_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Biases random lookups toward PCs that were recently trained.
    logic [31:0] last_upd_pc = 32'h40;
    always @(posedge clk) if (update_valid) last_upd_pc <= update_pc;

    function automatic logic [31:0] upc_prev_or_rand();
        return ($urandom_range(0, 1) == 0) ? last_upd_pc : rand_pc();
    endfunction

endmodule
